// File: rtl/video_timing_gen.sv
// Raster timing generator: hsync/vsync/de, active-pixel coordinates and a
// frame-start strobe. Raster is held idle until the synchronized PLL lock has
// been continuously high (with enable) for SETTLE_CYCLES pixel clocks.
// Optional build macro VTG_TEST_PATTERN_EN adds a colour-bar output pat_rgb.
module video_timing_gen #(
  parameter int H_ACTIVE      = 1280,
  parameter int H_FP          = 110,
  parameter int H_SYNC        = 40,
  parameter int H_BP          = 220,
  parameter int V_ACTIVE      = 720,
  parameter int V_FP          = 5,
  parameter int V_SYNC        = 5,
  parameter int V_BP          = 20,
  parameter bit SYNC_POL      = 1'b1,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CW            = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          running
`ifdef VTG_TEST_PATTERN_EN
  ,
  output logic [23:0]   pat_rgb
`endif
);

  localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam int            SW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          lock_m_q, lock_s_q;

  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic          frame_start_q, frame_start_d, running_q, running_d;
  logic          run_d;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      lock_m_q <= pll_locked;
      lock_s_q <= lock_m_q;
    end
  end

  // Next state, settle counter and raster counters; counters are zero outside RUN.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d  = state_q;
    settle_d = '0;
    h_d      = '0;
    v_d      = '0;
    unique case (state_q)
      WAIT_LOCK: if (lock_s_q && enable) state_d = SETTLE;
      SETTLE: begin
        if (!lock_s_q || !enable)        state_d = WAIT_LOCK;
        else if (settle_q == SETTLE_LAST) state_d = RUN;
        else                              settle_d = settle_q + 1'b1;
      end
      RUN: begin
        if (!lock_s_q || !enable) begin
          state_d = WAIT_LOCK;
        end else if (h_q == H_LAST) begin
          v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
          v_d = v_q;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Output decode from next-state counters so registered outputs line up with them.
  always_comb begin
    run_d         = (state_d == RUN);
    de_d          = run_d && (h_d < H_ACT) && (v_d < V_ACT);
    hsync_d       = (run_d && h_d >= HS_START && h_d < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (run_d && v_d >= VS_START && v_d < VS_END) ? SYNC_POL : ~SYNC_POL;
    pix_x_d       = de_d ? h_d : '0;
    pix_y_d       = de_d ? v_d : '0;
    frame_start_d = run_d && (h_d == '0) && (v_d == '0);
    running_d     = run_d;
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_LOCK;
      settle_q      <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

`ifdef VTG_TEST_PATTERN_EN
  localparam int            BAR_INT = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [CW-1:0] BAR_W   = CW'(BAR_INT);

  logic [CW-1:0] bar_full;
  logic [2:0]    bar_idx;
  logic [23:0]   pat_rgb_q, pat_rgb_d;

  // Eight vertical bars; columns beyond the eighth bar fall into black.
  always_comb begin
    bar_full = h_d / BAR_W;
    bar_idx  = (bar_full > CW'(7)) ? 3'd7 : bar_full[2:0];
    pat_rgb_d = 24'h000000;
    if (de_d) begin
      unique case (bar_idx)
        3'd0:    pat_rgb_d = 24'hFFFFFF;
        3'd1:    pat_rgb_d = 24'hFFFF00;
        3'd2:    pat_rgb_d = 24'h00FFFF;
        3'd3:    pat_rgb_d = 24'h00FF00;
        3'd4:    pat_rgb_d = 24'hFF00FF;
        3'd5:    pat_rgb_d = 24'hFF0000;
        3'd6:    pat_rgb_d = 24'h0000FF;
        default: pat_rgb_d = 24'h000000;
      endcase
    end
  end

  // Pattern register, aligned with de.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pat_rgb_q <= '0;
    else        pat_rgb_q <= pat_rgb_d;
  end

  assign pat_rgb = pat_rgb_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a reduced raster so full
// frames fit in a short run. Two instances (active-high and active-low syncs)
// share the stimulus. Expected outputs come from a lock-streak model: the
// raster index is how long the synchronized lock and enable have both held.
module tb_video_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;   // 25
  localparam int VT = VA + VFP + VS + VBP;   // 11
  localparam int FRAME = HT * VT;            // 275
  localparam int S  = 20;
  localparam int CW = 12;
  // Lock driven high before edge 1 reaches the FSM at edge 3; S settle cycles later RUN.
  localparam int START_LAT = S + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b1;
  logic enable = 1'b1;

  logic hs_p, vs_p, de_p, fs_p, run_p, hs_n, vs_n, de_n, fs_n, run_n;
  logic [CW-1:0] px_p, py_p, px_n, py_n;
  logic [23:0] pat_p, pat_n;
  logic [63:0] obs_p, obs_n;

  always #5 clk = ~clk;

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b1),
    .SETTLE_CYCLES(S), .CW(CW)) dut_p (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .enable(enable),
    .hsync(hs_p), .vsync(vs_p), .de(de_p), .pix_x(px_p), .pix_y(py_p),
    .frame_start(fs_p), .running(run_p)
`ifdef VTG_TEST_PATTERN_EN
    , .pat_rgb(pat_p)
`endif
  );

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0),
    .SETTLE_CYCLES(S), .CW(CW)) dut_n (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .enable(enable),
    .hsync(hs_n), .vsync(vs_n), .de(de_n), .pix_x(px_n), .pix_y(py_n),
    .frame_start(fs_n), .running(run_n)
`ifdef VTG_TEST_PATTERN_EN
    , .pat_rgb(pat_n)
`endif
  );

`ifndef VTG_TEST_PATTERN_EN
  assign pat_p = 24'h0;
  assign pat_n = 24'h0;
`endif

  assign obs_p = {11'b0, pat_p, run_p, de_p, hs_p, vs_p, fs_p, px_p, py_p};
  assign obs_n = {11'b0, pat_n, run_n, de_n, hs_n, vs_n, fs_n, px_n, py_n};

  typedef struct packed { logic [63:0] p; logic [63:0] n; } sb_t;
  sb_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int streak = 0;
  bit pl_d1 = 1'b0, pl_d2 = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int x);
    case (x / (HA / 8))
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [63:0] pack_exp(input bit run, input int idx, input bit pol);
    int h, v;
    bit de_e, hs_e, vs_e, fs_e;
    logic [23:0] pat;
    if (!run) return {11'b0, 24'h0, 1'b0, 1'b0, ~pol, ~pol, 1'b0, 12'd0, 12'd0};
    h    = idx % HT;
    v    = (idx / HT) % VT;
    de_e = (h < HA) && (v < VA);
    hs_e = (h >= HA + HFP && h < HA + HFP + HS) ? pol : ~pol;
    vs_e = (v >= VA + VFP && v < VA + VFP + VS) ? pol : ~pol;
    fs_e = (h == 0) && (v == 0);
    pat  = 24'h0;
`ifdef VTG_TEST_PATTERN_EN
    if (de_e) pat = bar_rgb(h);
`endif
    return {11'b0, pat, 1'b1, de_e, hs_e, vs_e, fs_e,
            de_e ? 12'(h) : 12'd0, de_e ? 12'(v) : 12'd0};
  endfunction

  // One clock: predict the coming edge from the driven inputs, then compare.
  task automatic step();
    sb_t e;
    if (!rst_n) begin
      streak = 0; pl_d1 = 1'b0; pl_d2 = 1'b0;
    end else begin
      streak = (pl_d2 && enable) ? streak + 1 : 0;
      pl_d2  = pl_d1;
      pl_d1  = pll_locked;
    end
    e.p = pack_exp(streak >= S + 1, streak - (S + 1), 1'b1);
    e.n = pack_exp(streak >= S + 1, streak - (S + 1), 1'b0);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check("out_pos", obs_p, e.p);
    check("out_neg", obs_n, e.n);
  endtask

  // Step until running reaches level; compare the number of steps taken.
  task automatic wait_running(input string tag, input bit level, input int want);
    int lat = -1;
    for (int i = 1; i <= want + 20; i++) begin
      step();
      if (run_p == level) begin lat = i; break; end
    end
    check(tag, 64'(lat), 64'(want));
  endtask

  initial begin
    int de_cnt = 0, fs_cnt = 0, hs_cnt = 0, vs_cnt = 0, max_x = 0, max_y = 0;
    @(negedge clk);
    repeat (3) step();                      // held in reset, lock already high
    rst_n = 1'b1;
    wait_running("start_latency", 1'b1, START_LAT);
    check("start_fs", 64'(fs_p), 64'd1);

    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      de_cnt += int'(de_p);
      fs_cnt += int'(fs_p);
      hs_cnt += int'(hs_p);
      vs_cnt += int'(vs_p);
      if (int'(px_p) > max_x) max_x = int'(px_p);
      if (int'(py_p) > max_y) max_y = int'(py_p);
    end
    check("de_cycles", 64'(de_cnt), 64'(2 * HA * VA));
    check("frame_starts", 64'(fs_cnt), 64'd2);
    check("hsync_cycles", 64'(hs_cnt), 64'(2 * VT * HS));
    check("vsync_cycles", 64'(vs_cnt), 64'(2 * VS * HT));
    check("max_x", 64'(max_x), 64'(HA - 1));
    check("max_y", 64'(max_y), 64'(VA - 1));

    // Lock loss mid-frame, then full re-settle to a fresh frame.
    repeat (3 * HT + 5) step();
    pll_locked = 1'b0;
    wait_running("lock_loss_latency", 1'b0, 3);
    repeat (4) step();
    pll_locked = 1'b1;
    wait_running("relock_latency", 1'b1, START_LAT);
    check("relock_origin", {62'b0, fs_p, de_p}, 64'd3);

    // Enable drop mid-line leaves RUN on the next edge.
    repeat (HT + 7) step();
    enable = 1'b0;
    wait_running("enable_drop_latency", 1'b0, 1);
    enable = 1'b1;

    // Lock glitch part-way through SETTLE restarts the whole settle period.
    repeat (S / 2) step();
    pll_locked = 1'b0;
    repeat (4) step();
    pll_locked = 1'b1;
    wait_running("glitch_restart", 1'b1, START_LAT);
    repeat (FRAME / 2) step();

    // Asynchronous reset takes effect between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pos", obs_p, pack_exp(1'b0, 0, 1'b1));
    check("async_rst_neg", obs_n, pack_exp(1'b0, 0, 1'b0));
    @(negedge clk);
    repeat (2) step();
    rst_n = 1'b1;
    wait_running("post_reset_start", 1'b1, START_LAT);
    repeat (HT + 3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
